// File: rtl/flash_prog_pkg.sv
// Command codes and sequencer state encoding for the flash programming path.
// Build option FLASH_PROG_VERIFY_EN adds the read-back verify states.
package flash_prog_pkg;

    localparam int unsigned CMD_W = 4;

    localparam logic [CMD_W-1:0] FLASH_ERS_SECT = 4'hA;
    localparam logic [CMD_W-1:0] FLASH_RD_ID    = 4'hB;
    localparam logic [CMD_W-1:0] FLASH_WR_PG    = 4'hC;
    localparam logic [CMD_W-1:0] FLASH_RD_PG    = 4'hD;
    localparam logic [CMD_W-1:0] FLASH_RD_SR    = 4'hE;
    localparam logic [CMD_W-1:0] FLASH_RD_FR    = 4'hF;

`ifdef FLASH_PROG_VERIFY_EN
    typedef enum logic [3:0] {
        S_IDLE,
        S_CALC,
        S_ERASE,
        S_WT_ERASE,
        S_WT_DATA,
        S_PROG,
        S_WT_PROG,
        S_VERIFY,
        S_WT_VERIFY,
        S_DONE,
        S_FAULT
    } seq_state_t;
`else
    typedef enum logic [3:0] {
        S_IDLE,
        S_CALC,
        S_ERASE,
        S_WT_ERASE,
        S_WT_DATA,
        S_PROG,
        S_WT_PROG,
        S_DONE,
        S_FAULT
    } seq_state_t;
`endif

endpackage

// File: rtl/flash_chunk_calc.sv
// Page-chunk size and erase-sector count for a byte range; purely combinational.
module flash_chunk_calc #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned PG_W   = 8,
    parameter int unsigned SECT_W = 12
) (
    input  logic [SECT_W-1:0] addr_lo,
    input  logic [ADDR_W-1:0] len,
    output logic [PG_W:0]     chunk_c,
    output logic [ADDR_W-1:0] n_sect_c
);

    localparam int unsigned CHUNK_W = PG_W + 1;
    localparam int unsigned SUM_W   = ADDR_W + 1;
    localparam logic [CHUNK_W-1:0] PAGE_SIZE = CHUNK_W'(1) << PG_W;
    localparam logic [SECT_W-1:0]  SECT_MASK = '1;

    logic [CHUNK_W-1:0] room;
    logic [SUM_W-1:0]   sect_sum;

    // Bytes left in the current page, capped by the remaining length
    always_comb begin
        room     = PAGE_SIZE - CHUNK_W'(addr_lo[PG_W-1:0]);
        chunk_c  = (len < ADDR_W'(room)) ? CHUNK_W'(len) : room;
        sect_sum = SUM_W'(addr_lo) + SUM_W'(len) + SUM_W'(SECT_MASK);
        n_sect_c = ADDR_W'(sect_sum >> SECT_W);
    end

endmodule

// File: rtl/flash_prog_sequencer.sv
// Erase-then-program sequencer feeding the flash macro executor one command at a time.
// Define FLASH_PROG_VERIFY_EN to read back and compare every programmed page.
module flash_prog_sequencer
    import flash_prog_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned PG_W   = 8,
    parameter int unsigned SECT_W = 12,
    parameter int unsigned LVL_W  = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] data_len,
    input  logic              abort,
    input  logic [LVL_W-1:0]  buff_level,
    output logic [CMD_W-1:0]  cmd,
    output logic              cmd_valid,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [PG_W:0]     cmd_len,
    input  logic              cmd_done,
    input  logic              cmd_err,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] pages_done
);

    localparam int unsigned CHUNK_W = PG_W + 1;
    localparam int unsigned LVL_CMP_W = (LVL_W > CHUNK_W) ? LVL_W : CHUNK_W;
    localparam logic [ADDR_W-1:0] SECT_STEP = ADDR_W'(1) << SECT_W;

    seq_state_t state_q, state_d;

    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [ADDR_W-1:0]  rem_q, rem_d;
    logic [ADDR_W-1:0]  era_q, era_d;
    logic [ADDR_W-1:0]  nsect_q, nsect_d;
    logic               abort_q, abort_d;

    logic               busy_d, done_d, error_d, cmd_valid_d;
    logic [ADDR_W-1:0]  pages_d, cmd_addr_d;
    logic [CMD_W-1:0]   cmd_d;
    logic [CHUNK_W-1:0] cmd_len_d;

    logic [CHUNK_W-1:0] chunk;
    logic [ADDR_W-1:0]  n_sect;
    logic               rsp;
    logic               abort_any;

    flash_chunk_calc #(
        .ADDR_W (ADDR_W),
        .PG_W   (PG_W),
        .SECT_W (SECT_W)
    ) u_calc (
        .addr_lo  (addr_q[SECT_W-1:0]),
        .len      (rem_q),
        .chunk_c  (chunk),
        .n_sect_c (n_sect)
    );

    // A completion coinciding with the strobe is illegal and dropped
    assign rsp       = cmd_done & ~cmd_valid;
    assign abort_any = abort_q | abort;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        era_d       = era_q;
        nsect_d     = nsect_q;
        abort_d     = abort_q | (busy & abort);
        busy_d      = busy;
        done_d      = 1'b0;
        error_d     = error;
        pages_d     = pages_done;
        cmd_d       = cmd;
        cmd_valid_d = 1'b0;
        cmd_addr_d  = cmd_addr;
        cmd_len_d   = cmd_len;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d  = start_addr;
                    rem_d   = data_len;
                    error_d = 1'b0;
                    pages_d = '0;
                    busy_d  = 1'b1;
                    abort_d = 1'b0;
                    state_d = (data_len == '0) ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                nsect_d = n_sect;
                era_d   = {addr_q[ADDR_W-1:SECT_W], {SECT_W{1'b0}}};
                state_d = S_ERASE;
            end
            // Erase carries no byte count
            S_ERASE: begin
                cmd_d       = FLASH_ERS_SECT;
                cmd_valid_d = 1'b1;
                cmd_addr_d  = era_q;
                cmd_len_d   = '0;
                state_d     = S_WT_ERASE;
            end
            S_WT_ERASE: begin
                if (rsp) begin
                    if (cmd_err) begin
                        state_d = S_FAULT;
                    end else begin
                        era_d   = era_q + SECT_STEP;
                        nsect_d = nsect_q - ADDR_W'(1);
                        if (abort_any)                   state_d = S_FAULT;
                        else if (nsect_q == ADDR_W'(1))  state_d = S_WT_DATA;
                        else                             state_d = S_ERASE;
                    end
                end
            end
            S_WT_DATA: begin
                if (abort_any)
                    state_d = S_FAULT;
                else if (LVL_CMP_W'(buff_level) >= LVL_CMP_W'(chunk))
                    state_d = S_PROG;
            end
            S_PROG: begin
                cmd_d       = FLASH_WR_PG;
                cmd_valid_d = 1'b1;
                cmd_addr_d  = addr_q;
                cmd_len_d   = chunk;
                state_d     = S_WT_PROG;
            end
            S_WT_PROG: begin
                if (rsp) begin
                    if (cmd_err) begin
                        state_d = S_FAULT;
`ifdef FLASH_PROG_VERIFY_EN
                    end else if (abort_any) begin
                        state_d = S_FAULT;
                    end else begin
                        state_d = S_VERIFY;
                    end
                end
            end
            S_VERIFY: begin
                cmd_d       = FLASH_RD_PG;
                cmd_valid_d = 1'b1;
                cmd_addr_d  = addr_q;
                state_d     = S_WT_VERIFY;
            end
            S_WT_VERIFY: begin
                if (rsp) begin
                    if (cmd_err) begin
                        state_d = S_FAULT;
`endif
                    end else begin
                        addr_d  = addr_q + ADDR_W'(cmd_len);
                        rem_d   = rem_q - ADDR_W'(cmd_len);
                        pages_d = pages_done + ADDR_W'(1);
                        if (abort_any)                        state_d = S_FAULT;
                        else if (rem_q == ADDR_W'(cmd_len))  state_d = S_DONE;
                        else                                  state_d = S_WT_DATA;
                    end
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            S_FAULT: begin
                error_d = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            era_q      <= '0;
            nsect_q    <= '0;
            abort_q    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            pages_done <= '0;
            cmd        <= '0;
            cmd_valid  <= 1'b0;
            cmd_addr   <= '0;
            cmd_len    <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            era_q      <= era_d;
            nsect_q    <= nsect_d;
            abort_q    <= abort_d;
            busy       <= busy_d;
            done       <= done_d;
            error      <= error_d;
            pages_done <= pages_d;
            cmd        <= cmd_d;
            cmd_valid  <= cmd_valid_d;
            cmd_addr   <= cmd_addr_d;
            cmd_len    <= cmd_len_d;
        end
    end

endmodule

// File: tb/tb_flash_prog_sequencer.sv
// Self-checking bench for flash_prog_sequencer with a responding executor model.
`timescale 1ns/1ps
module tb_flash_prog_sequencer;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned PG_W   = 8;
    localparam int unsigned SECT_W = 12;
    localparam int unsigned LVL_W  = 12;

    typedef struct packed {
        logic [3:0]  c;
        logic [31:0] a;
        logic [8:0]  l;
    } ent_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] data_len;
    logic              abort;
    logic [LVL_W-1:0]  buff_level;
    logic [3:0]        cmd;
    logic              cmd_valid;
    logic [ADDR_W-1:0] cmd_addr;
    logic [PG_W:0]     cmd_len;
    logic              cmd_done;
    logic              cmd_err;
    logic              busy;
    logic              done;
    logic              error;
    logic [ADDR_W-1:0] pages_done;

    int   n_cmp = 0;
    int   n_mis = 0;
    ent_t cmd_log[$];
    int   n_overlap = 0;
    int   n_unstable = 0;
    int   n_done_seen = 0;
    int   n_valid_seen = 0;
    int   err_idx = -1;
    logic [LVL_W-1:0] buff_fixed = 12'hFFF;
    bit   buff_rand = 1'b0;

    flash_prog_sequencer #(
        .ADDR_W (ADDR_W),
        .PG_W   (PG_W),
        .SECT_W (SECT_W),
        .LVL_W  (LVL_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .data_len   (data_len),
        .abort      (abort),
        .buff_level (buff_level),
        .cmd        (cmd),
        .cmd_valid  (cmd_valid),
        .cmd_addr   (cmd_addr),
        .cmd_len    (cmd_len),
        .cmd_done   (cmd_done),
        .cmd_err    (cmd_err),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .pages_done (pages_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done)      n_done_seen  <= n_done_seen + 1;
        if (cmd_valid) n_valid_seen <= n_valid_seen + 1;
    end

    // Buffer fill level: fixed value or random churn
    initial begin : buff_drv
        buff_level = '0;
        forever begin
            @(posedge clk); #1;
            buff_level = buff_rand ? LVL_W'($urandom_range(0, 300)) : buff_fixed;
        end
    end

    // Executor: logs each command, answers after a random delay
    initial begin : executor
        ent_t e;
        int   idx;
        int   dly;
        bit   ok;
        cmd_done = 1'b0;
        cmd_err  = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (rst_n && cmd_valid) begin
                e.c = cmd;
                e.a = cmd_addr;
                e.l = cmd_len;
                cmd_log.push_back(e);
                idx = cmd_log.size() - 1;
                dly = int'($urandom_range(1, 4));
                ok  = 1'b1;
                for (int k = 0; k < dly; k++) begin
                    @(posedge clk); #1;
                    if (!rst_n) ok = 1'b0;
                    else if (ok) begin
                        if (cmd_valid) n_overlap++;
                        if ({cmd, cmd_addr, cmd_len} != e) n_unstable++;
                    end
                end
                if (ok) begin
                    cmd_done = 1'b1;
                    cmd_err  = (idx == err_idx);
                    @(posedge clk); #1;
                    cmd_done = 1'b0;
                    cmd_err  = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: run still active, observed busy=%0b, required completion", busy);
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [31:0] a, input logic [31:0] l);
        @(posedge clk); #1;
        start_addr = a;
        data_len   = l;
        start      = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_finish"}, busy, 0);
        repeat (2) @(negedge clk);
    endtask

    // Reference: erase every sector touched, then page-bounded writes
    task automatic check_job(input string tag, input logic [31:0] a, input logic [31:0] l,
                             input int log0, input int done0);
        ent_t exp_q[$];
        ent_t e;
        longint unsigned first, last, cur, rem, room, n;
        int n_pg;
        int got;
        n_pg  = 0;
        first = longint'(a) >> SECT_W;
        last  = (longint'(a) + longint'(l) - 1) >> SECT_W;
        for (longint unsigned s = first; s <= last; s++) begin
            e.c = 4'hA; e.a = 32'(s << SECT_W); e.l = 9'd0;
            exp_q.push_back(e);
        end
        cur = longint'(a);
        rem = longint'(l);
        while (rem > 0) begin
            room = 256 - (cur % 256);
            n    = (rem < room) ? rem : room;
            e.c = 4'hC; e.a = 32'(cur); e.l = 9'(n);
            exp_q.push_back(e);
`ifdef FLASH_PROG_VERIFY_EN
            e.c = 4'hD;
            exp_q.push_back(e);
`endif
            n_pg++;
            cur += n;
            rem -= n;
        end
        got = cmd_log.size() - log0;
        chk({tag, "_ncmd"}, got, exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got; i++) begin
            chk($sformatf("%s_cmd%0d_code", tag, i), cmd_log[log0+i].c, exp_q[i].c);
            chk($sformatf("%s_cmd%0d_addr", tag, i), cmd_log[log0+i].a, exp_q[i].a);
            if (exp_q[i].c != 4'hA)
                chk($sformatf("%s_cmd%0d_len", tag, i), cmd_log[log0+i].l, exp_q[i].l);
        end
        chk({tag, "_pages"}, pages_done, n_pg);
        chk({tag, "_donecnt"}, n_done_seen - done0, 1);
        chk({tag, "_error"}, error, 0);
    endtask

    task automatic run_checked(input string tag, input logic [31:0] a, input logic [31:0] l);
        int log0, d0;
        log0 = cmd_log.size();
        d0   = n_done_seen;
        launch(a, l);
        wait_idle(tag, 4000);
        check_job(tag, a, l, log0, d0);
    endtask

    initial begin : main
        int log0, d0, v0, n;
        bit seen;
        logic [31:0] ra, rl;
        rst_n = 1'b0; start = 1'b0; start_addr = '0; data_len = '0; abort = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmdbus", {cmd, cmd_valid, cmd_addr, cmd_len}, 0);
        chk("rst_status", {busy, done, error, pages_done}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_quiet", {busy, cmd_valid, done}, 0);

        run_checked("two_pages", 32'h0, 32'h200);
        run_checked("straddle", 32'h0FF0, 32'h20);

        // Zero length: done two cycles after start, no commands
        v0 = n_valid_seen;
        launch(32'h40, 32'h0);
        @(negedge clk);
        chk("len0_busy", busy, 1);
        chk("len0_done_early", done, 0);
        @(negedge clk);
        chk("len0_done", done, 1);
        chk("len0_busy_clr", busy, 0);
        @(negedge clk);
        chk("len0_done_once", done, 0);
        chk("len0_nocmd", n_valid_seen - v0, 0);
        chk("len0_error", error, 0);

        // Starved buffer holds the sequencer in WT_DATA
        buff_fixed = 12'd100;
        log0 = cmd_log.size();
        d0   = n_done_seen;
        v0   = n_valid_seen;
        launch(32'h0, 32'h100);
        repeat (30) @(negedge clk);
        chk("stall_ncmd", cmd_log.size() - log0, 1);
        chk("stall_nvalid", n_valid_seen - v0, 1);
        chk("stall_busy", busy, 1);
        buff_fixed = 12'd256;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 6) begin
            @(negedge clk);
            n++;
            if (cmd_valid) seen = 1'b1;
        end
        chk("stall_release", seen, 1);
        chk("stall_release_cmd", cmd, 4'hC);
        wait_idle("stall", 400);
        check_job("stall", 32'h0, 32'h100, log0, d0);
        buff_fixed = 12'hFFF;

        // Executor failure on the second erase
        log0 = cmd_log.size();
        d0   = n_done_seen;
        err_idx = log0 + 1;
        launch(32'h0FF0, 32'h20);
        wait_idle("erserr", 400);
        chk("erserr_error", error, 1);
        chk("erserr_busy", busy, 0);
        chk("erserr_ncmd", cmd_log.size() - log0, 2);
        chk("erserr_nodone", n_done_seen - d0, 0);
        err_idx = -1;
        d0 = n_done_seen;
        launch(32'h0, 32'h0);
        chk("erserr_cleared", error, 0);
        wait_idle("erserr_restart", 50);
        chk("erserr_restart_done", n_done_seen - d0, 1);

        // Abort during the first erase
        log0 = cmd_log.size();
        d0   = n_done_seen;
        launch(32'h0, 32'h300);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        wait_idle("abort", 400);
        chk("abort_error", error, 1);
        chk("abort_ncmd", cmd_log.size() - log0, 1);
        chk("abort_nodone", n_done_seen - d0, 0);

        // Asynchronous reset while the second page write is outstanding
        launch(32'h100, 32'h200);
        seen = 1'b0;
        n = 0;
        while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            if (cmd_valid && cmd == 4'hC && cmd_addr == 32'h200) seen = 1'b1;
        end
        chk("rstmid_reached", seen, 1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_cmdbus", {cmd, cmd_valid, cmd_addr, cmd_len}, 0);
        chk("rstmid_status", {busy, done, error, pages_done}, 0);
        repeat (8) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_checked("after_rst", 32'h0FF0, 32'h20);

        // Random ranges with a churning buffer level
        buff_rand = 1'b1;
        for (int j = 0; j < 10; j++) begin
            ra = 32'($urandom_range(0, 32'h3FFF));
            rl = 32'($urandom_range(1, 900));
            run_checked($sformatf("rnd%0d", j), ra, rl);
        end
        buff_rand = 1'b0;

        chk("proto_overlap", n_overlap, 0);
        chk("proto_stable", n_unstable, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
